// File: rtl/aes_pkg.sv
// aes_pkg: shared types, constants and byte/word helpers for the AES key schedule.
package aes_pkg;

    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    localparam int         AES_NUM_RK = 11;
    localparam logic [7:0] RCON_INIT  = 8'h01;
    localparam logic [7:0] RCON_POLY  = 8'h1B;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// aes_key_sched_ctrl_if: key-load / round-key stream bundle; the read port and
// store_full exist only when AES_KEYSCHED_STORE_EN is defined.
interface aes_key_sched_ctrl_if;
    logic         start;
    logic [127:0] key_in;
    logic         ready;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;
    logic         done;
`ifdef AES_KEYSCHED_STORE_EN
    logic [3:0]   rd_idx;
    logic [127:0] rd_data;
    logic         store_full;
`endif

    modport master (
        output start, key_in, rk_ready,
        input  ready, rk_valid, rk_data, rk_idx, done
`ifdef AES_KEYSCHED_STORE_EN
        , output rd_idx
        , input  rd_data, store_full
`endif
    );

    modport slave (
        input  start, key_in, rk_ready,
        output ready, rk_valid, rk_data, rk_idx, done
`ifdef AES_KEYSCHED_STORE_EN
        , input  rd_idx
        , output rd_data, store_full
`endif
    );
endinterface

// File: rtl/aes_key_sched_ctrl_subword.sv
// aes_key_sched_ctrl_subword: combinational SubWord, four S-boxes computed as
// GF(2^8) inverse (x^254) followed by the AES affine transform.
module aes_key_sched_ctrl_subword
    import aes_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ t : p;
            t = xtime(t);
        end
        return p;
    endfunction

    // x^127 by square-and-multiply, one more squaring gives x^254 = x^-1 (0 maps to 0)
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), x);
        r = gf_mul(r, r);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_sb
        assign o_word[8*g +: 8] = sbox(i_word[8*g +: 8]);
    end
endmodule

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: AES-128 key expansion sequencer streaming round keys 0..10.
// Define AES_KEYSCHED_STORE_EN to add the 11-entry round-key store with read port.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input logic                 clk,
    input logic                 rst_n,
    aes_key_sched_ctrl_if.slave bus
);
    state_t       r_state, w_state_nxt;
    logic [127:0] r_key, w_key_nxt;
    logic [3:0]   r_idx;
    logic [7:0]   r_rcon;
    logic [31:0]  w_rot, w_sub, w_temp, w_w0, w_w1, w_w2, w_w3;
    logic         w_accept, w_hs, w_last;

    assign w_accept = (r_state == IDLE) && bus.start;
    assign w_hs     = (r_state == EMIT) && bus.rk_ready;
    assign w_last   = r_idx == 4'(NUM_ROUNDS);

    assign w_rot = rot_word(r_key[31:0]);
    aes_key_sched_ctrl_subword u_subword (.i_word(w_rot), .o_word(w_sub));

    assign w_temp    = w_sub ^ {r_rcon, 24'h0};
    assign w_w0      = r_key[127:96] ^ w_temp;
    assign w_w1      = r_key[95:64] ^ w_w0;
    assign w_w2      = r_key[63:32] ^ w_w1;
    assign w_w3      = r_key[31:0] ^ w_w2;
    assign w_key_nxt = {w_w0, w_w1, w_w2, w_w3};

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = bus.start ? EMIT : IDLE;
            EMIT:    w_state_nxt = (w_hs && w_last) ? DONE : EMIT;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_key  <= '0;
            r_idx  <= '0;
            r_rcon <= RCON_INIT;
        end else if (w_accept) begin
            r_key  <= bus.key_in;
            r_idx  <= '0;
            r_rcon <= RCON_INIT;
        end else if (w_hs && !w_last) begin
            r_key  <= w_key_nxt;
            r_idx  <= r_idx + 4'd1;
            r_rcon <= xtime(r_rcon);
        end
    end

    assign bus.ready    = r_state == IDLE;
    assign bus.rk_valid = r_state == EMIT;
    assign bus.done     = r_state == DONE;
    assign bus.rk_data  = r_key;
    assign bus.rk_idx   = r_idx;

`ifdef AES_KEYSCHED_STORE_EN
    logic [127:0] r_store [AES_NUM_RK];
    logic         r_full;

    // contents are deliberately left unreset; only the full flag is
    always_ff @(posedge clk) begin
        if (w_hs) r_store[r_idx] <= r_key;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)               r_full <= 1'b0;
        else if (w_accept)        r_full <= 1'b0;
        else if (w_hs && w_last)  r_full <= 1'b1;
    end

    assign bus.rd_data    = (bus.rd_idx < 4'(AES_NUM_RK)) ? r_store[bus.rd_idx] : '0;
    assign bus.store_full = r_full;
`endif
endmodule
